pattern_scan_ctrl: RTL

Frame-level controller that drives a programmable serial pattern matcher from a byte stream. It accepts a run-time pattern of 1..MAX_LEN bits and an overlap/non-overlap mode, and pulls bytes over a valid/ready interface. It serialises each byte MSB-first into the matcher, counts matches across the whole frame, and reports completion. It sits between a byte-wide source (UART/FIFO) and status logic that needs sequence-detect results per frame.

---
 rtl/pattern_scan_pkg.sv | 16 +
 rtl/pattern_scan_ctrl_matcher.sv | 64 ++++++
 rtl/pattern_scan_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared definitions for the pattern scan controller.
// Holds the FSM state encoding and the default sizing parameters
// used by pattern_scan_ctrl and pattern_matcher.
package pattern_scan_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_scan_ctrl_matcher.sv
// Serial pattern matcher with a run-time length and overlap mode.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   bit_valid    bit_in carries a stream bit this cycle
//   bit_in       serial stream bit
//   clear        synchronous clear of history, bits-seen count and match
//   len          pattern length (1..MAX_LEN); must be held stable during a frame
//   pattern      pattern; bit len-1 is the oldest expected bit, bit 0 the newest
//   overlap      1 = overlapping detection, 0 = restart after each match
//   match        registered one-cycle pulse, high the cycle after the
//                matching bit was presented
module pattern_matcher #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_valid,
    input  logic               bit_in,
    input  logic               clear,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               match
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   seen_q;
    logic [LEN_W-1:0]   seen_nxt;
    logic               hit;

    always_comb begin
        hist_nxt = {hist_q[MAX_LEN-2:0], bit_in};
        // Bits-seen saturates at MAX_LEN; that is enough to qualify any length.
        seen_nxt = (seen_q == LEN_W'(MAX_LEN)) ? seen_q : seen_q + LEN_W'(1);
        // Low len bits set; a shift by MAX_LEN yields all ones.
        mask     = ~({MAX_LEN{1'b1}} << len);
        hit      = bit_valid && (seen_nxt >= len) &&
                   ((hist_nxt & mask) == (pattern & mask));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            seen_q <= '0;
            match  <= 1'b0;
        end else if (clear) begin
            hist_q <= '0;
            seen_q <= '0;
            match  <= 1'b0;
        end else begin
            match <= hit;
            if (bit_valid) begin
                hist_q <= hist_nxt;
                // Non-overlap mode: the matched bits cannot be reused.
                seen_q <= (hit && !overlap) ? '0 : seen_nxt;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Frame-level controller feeding a byte stream, MSB first, into a
// programmable serial pattern matcher and counting matches per frame.
//
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   start         begin a frame (only looked at in IDLE)
//   cfg_pattern   pattern, latched on an accepted start
//   cfg_len       pattern length 1..MAX_LEN, latched on an accepted start
//   cfg_overlap   overlap mode, latched on an accepted start
//   in_valid/in_data/in_last/in_ready  byte input handshake
//   busy          high whenever the FSM is not in IDLE
//   match_pulse   one-cycle pulse per detected match
//   match_count   saturating match count for the current or last frame
//   done          one-cycle pulse at frame end
//   err_cfg       one-cycle pulse after a start with an illegal cfg_len
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high; in_ready is high only in FETCH and does not depend on
// in_valid. The source may hold in_valid low for any number of cycles.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               err_cfg
);

    state_t             state_q;
    state_t             state_d;
    logic [7:0]         byte_q;
    logic               last_q;
    logic [2:0]         bit_idx_q;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   count_q;
    logic               len_legal;
    logic               start_ok;
    logic               start_bad;
    logic               match;

    assign len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign start_ok  = (state_q == IDLE) && start && len_legal;
    assign start_bad = (state_q == IDLE) && start && !len_legal;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and decoded outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE:  if (start_ok) state_d = FETCH;
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: if (bit_idx_q == 3'd0) state_d = last_q ? DONE : FETCH;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Datapath: config latch, byte register, bit index, counter, error pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            byte_q    <= '0;
            last_q    <= 1'b0;
            bit_idx_q <= '0;
            count_q   <= '0;
            err_cfg   <= 1'b0;
        end else begin
            err_cfg <= start_bad;
            if (start_ok) begin
                pattern_q <= cfg_pattern;
                len_q     <= cfg_len;
                overlap_q <= cfg_overlap;
                count_q   <= '0;
            end else if (match && !(&count_q)) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (state_q == FETCH && in_valid) begin
                byte_q    <= in_data;
                last_q    <= in_last;
                bit_idx_q <= 3'd7;
            end else if (state_q == SHIFT) begin
                bit_idx_q <= bit_idx_q - 3'd1;
            end
        end
    end

    pattern_matcher #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_matcher (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (state_q == SHIFT),
        .bit_in    (byte_q[bit_idx_q]),
        .clear     (start_ok),
        .len       (len_q),
        .pattern   (pattern_q),
        .overlap   (overlap_q),
        .match     (match)
    );

    assign match_pulse = match;
    // The count register lags the registered match by a cycle; folding the
    // pending match in here makes the visible count move together with
    // match_pulse, so the count at done includes a final-bit match.
    assign match_count = (match && !(&count_q)) ? count_q + CNT_W'(1) : count_q;

endmodule
